lif_array_core: RTL and testbench
=================================

Name: lif_array_core

Overview:
- Time-multiplexed array of N leaky integrate-and-fire neurons sharing one update datapath.
- Each neuron has an adaptive threshold and a refractory period.
- Per-neuron input currents are written through a register port. A step handshake sweeps all neurons, one per cycle.
- Spike events are queued in a FIFO with valid/ready output, for the SNN fabric and the TT pin wrapper.

Parameters:
N_NEURONS, 4, neuron count (>=2); index width NW = $clog2(N_NEURONS)
V_WIDTH, 8, membrane / current / threshold width (unsigned)
TAU_SHIFT, 3, leak time constant as a power of 2 (tau = 2^TAU_SHIFT)
THETA_BASE, 50, resting threshold
ADAPT_JUMP, 30, threshold increment on spike
REFRACT_STEPS, 3, refractory length in steps
FIFO_DEPTH, 4, spike event FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cur_we  in  1  write enable for the current register
cur_addr  in  NW  neuron index to write
cur_data  in  V_WIDTH  input current value
step_valid  in  1  request one sweep
step_ready  out  1  core idle; step can be accepted
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse after the last neuron is updated
spike_valid  out  1  FIFO head valid
spike_ready  in  1  consumer accepts the FIFO head
spike_idx  out  NW  index of the neuron that spiked
overflow  out  1  sticky: a spike event was dropped
mon_idx  in  NW  monitor select
mon_membrane  out  V_WIDTH  membrane of mon_idx (combinational read)
mon_threshold  out  V_WIDTH  threshold of mon_idx (combinational read)

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset:
  - all membranes 0, thresholds THETA_BASE, refractory counters 0, currents 0;
  - FIFO empty, spike_valid 0, overflow 0, busy 0, sweep_done 0, step_ready 1.
- Reset mid-sweep aborts the sweep; no partial state is retained.
- States:
  - IDLE: step_ready=1. step_valid&&step_ready at edge E moves to SWEEP.
  - SWEEP: busy=1, step_ready=0. Neuron i is updated at edge E+1+i, i = 0..N-1. Return to IDLE after edge E+N; sweep_done is high for the cycle following edge E+N.
  - step_valid is ignored while busy.
- Per-neuron update (V = membrane, I = current, θ = threshold, r = refractory count):
  - fire = (r==0) && (V >= θ).
  - If fire: V←0, r←REFRACT_STEPS, θ←min(θ+ADAPT_JUMP, 2^V_WIDTH−1) (saturating), event pushed.
  - Else if r>0: V←0, r←r−1.
  - Else: d = (I − V) computed signed in V_WIDTH+1 bits, arithmetic right shift by TAU_SHIFT (floor). V←clamp(V+d, 0, 2^V_WIDTH−1).
  - Threshold decay: when not firing and θ>THETA_BASE, θ←θ−1. Decay is applied on the refractory path too.
- Current write:
  - cur_we takes effect at the next edge, in any state.
  - If it hits the neuron being updated at the same edge, the update uses the old current.
  - Out-of-range cur_addr is ignored.
- Spike FIFO:
  - First-word fall-through.
  - Push and pop in the same cycle while full: the push is accepted.
  - Push while full without a pop: event dropped, overflow←1 until reset.
  - Events are ordered by neuron index within a sweep, and by sweep.
- Out-of-range mon_idx reads as 0.

Optional Feature:
THETA_ADAPT_EN
- Defined: adaptive threshold exactly as above.
- Undefined: no threshold registers; θ is the constant THETA_BASE for all neurons; ADAPT_JUMP is unused; mon_threshold = THETA_BASE.

Test Plan:
- Reset -> all mon_membrane 0, mon_threshold 50, step_ready 1, spike_valid 0, overflow 0. Reset asserted mid-sweep -> same values.
- Neuron 0, I=200, spike_ready=1:
  - steps 1–3 -> V 25, 46, 65;
  - step 4 -> spike_idx 0, V 0, θ 80;
  - steps 5–7 -> V 0, θ 79, 78, 77;
  - step 8 -> V 25.
- Neuron 1, V=46 then I=0 -> V 40 after one step (d=−6). With V=1, I=0 -> V 0, never below 0.
- FIFO overflow (FIFO_DEPTH=2), all I=255, spike_ready=0:
  - step 3 -> all 4 neurons fire; FIFO holds idx 0 then 1; overflow 1;
  - raise spike_ready -> 0, 1 popped, then spike_valid 0.
- Step handshake: step_valid accepted at edge E -> busy over edges E+1..E+4, sweep_done one cycle, step_ready 1 after. step_valid held during busy -> exactly one extra sweep, started after return to IDLE.
- Collision: write cur_addr=2, value 255, at the edge neuron 2 updates with old I=0 -> that update uses 0; the next sweep uses 255.

Source files
------------

// File: rtl/lif_array_core_if.sv
// Bus bundle for lif_array_core: current-write port, step handshake,
// spike event stream and the combinational monitor read.
// master = the driving side (fabric / wrapper), slave = the core.
interface lif_array_core_if #(
    parameter int N_NEURONS = 4,
    parameter int V_WIDTH   = 8
);
    localparam int NW = $clog2(N_NEURONS);

    logic               cur_we;
    logic [NW-1:0]      cur_addr;
    logic [V_WIDTH-1:0] cur_data;

    logic               step_valid;
    logic               step_ready;
    logic               busy;
    logic               sweep_done;

    logic               spike_valid;
    logic               spike_ready;
    logic [NW-1:0]      spike_idx;
    logic               overflow;

    logic [NW-1:0]      mon_idx;
    logic [V_WIDTH-1:0] mon_membrane;
    logic [V_WIDTH-1:0] mon_threshold;

    modport master (
        output cur_we, cur_addr, cur_data, step_valid, spike_ready, mon_idx,
        input  step_ready, busy, sweep_done, spike_valid, spike_idx, overflow,
               mon_membrane, mon_threshold
    );

    modport slave (
        input  cur_we, cur_addr, cur_data, step_valid, spike_ready, mon_idx,
        output step_ready, busy, sweep_done, spike_valid, spike_idx, overflow,
               mon_membrane, mon_threshold
    );
endinterface

// File: rtl/lif_array_core.sv
// Time-multiplexed leaky integrate-and-fire neuron array with one shared
// update datapath, refractory counters and a FWFT spike event FIFO.
// Optional macro THETA_ADAPT_EN: when defined, each neuron carries an
// adaptive threshold; otherwise the threshold is the constant THETA_BASE.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for step_valid; step_ready high
// ST_SWEEP | updating neuron idx_q this cycle, one neuron per clock
module lif_array_core #(
    parameter int N_NEURONS     = 4,
    parameter int V_WIDTH       = 8,
    parameter int TAU_SHIFT     = 3,
    parameter int THETA_BASE    = 50,
    parameter int ADAPT_JUMP    = 30,
    parameter int REFRACT_STEPS = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    lif_array_core_if.slave   bus
);
    localparam int NW = $clog2(N_NEURONS);
    localparam int RW = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [V_WIDTH-1:0] V_MAX        = '1;
    localparam logic [V_WIDTH-1:0] THETA_BASE_V = V_WIDTH'(THETA_BASE);
    localparam logic [RW-1:0]      REFRACT_V    = RW'(REFRACT_STEPS);
    localparam logic [NW:0]        N_V          = (NW+1)'(N_NEURONS);
    localparam logic [NW-1:0]      LAST_IDX     = NW'(N_NEURONS - 1);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      idx_q, idx_d;
    logic               sweep_done_q, sweep_done_d;
    logic               upd_en;

    logic [V_WIDTH-1:0] mem_q [N_NEURONS];
    logic [V_WIDTH-1:0] cur_q [N_NEURONS];
    logic [RW-1:0]      ref_q [N_NEURONS];

    logic [V_WIDTH-1:0] v_cur, i_cur, th_cur, mem_d;
    logic [RW-1:0]      r_cur, ref_d;
    logic               fire;
    logic signed [V_WIDTH:0]   diff, dlt;
    logic signed [V_WIDTH+1:0] sum;

    logic [NW-1:0]      fifo_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        cnt_q;
    logic               overflow_q;
    logic               push, pop, full, accept;

`ifdef THETA_ADAPT_EN
    logic [V_WIDTH-1:0] thr_q [N_NEURONS];
    logic [V_WIDTH-1:0] thr_d;
    logic [V_WIDTH:0]   th_sum;
`else
    // keeps ADAPT_JUMP referenced when adaptation is compiled out
    logic unused_adapt_jump;
    assign unused_adapt_jump = ^ADAPT_JUMP;
`endif

    // FSM state register and sweep index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // FSM next state: accept a step in IDLE, walk every neuron in SWEEP
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sweep_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.step_valid) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d      = ST_IDLE;
                    sweep_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.step_ready = (state_q == ST_IDLE);
        bus.busy       = (state_q == ST_SWEEP);
        upd_en         = (state_q == ST_SWEEP);
    end

    assign bus.sweep_done = sweep_done_q;

    // shared neuron update for neuron idx_q (reads old current on a write collision)
    always_comb begin
        v_cur = mem_q[idx_q];
        i_cur = cur_q[idx_q];
        r_cur = ref_q[idx_q];
`ifdef THETA_ADAPT_EN
        th_cur = thr_q[idx_q];
`else
        th_cur = THETA_BASE_V;
`endif
        fire = (r_cur == '0) && (v_cur >= th_cur);
        diff = $signed({1'b0, i_cur}) - $signed({1'b0, v_cur});
        dlt  = diff >>> TAU_SHIFT;
        sum  = $signed({2'b00, v_cur}) + $signed({dlt[V_WIDTH], dlt});
        if (fire) begin
            mem_d = '0;
            ref_d = REFRACT_V;
        end else if (r_cur != '0) begin
            mem_d = '0;
            ref_d = r_cur - 1'b1;
        end else begin
            ref_d = r_cur;
            if (sum[V_WIDTH+1])
                mem_d = '0;
            else if (sum[V_WIDTH])
                mem_d = V_MAX;
            else
                mem_d = sum[V_WIDTH-1:0];
        end
`ifdef THETA_ADAPT_EN
        th_sum = {1'b0, th_cur} + (V_WIDTH+1)'(ADAPT_JUMP);
        if (fire)
            thr_d = th_sum[V_WIDTH] ? V_MAX : th_sum[V_WIDTH-1:0];
        else if (th_cur > THETA_BASE_V)
            thr_d = th_cur - 1'b1;
        else
            thr_d = th_cur;
`endif
    end

    // membrane, refractory and current storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                mem_q[n] <= '0;
                ref_q[n] <= '0;
                cur_q[n] <= '0;
            end
        end else begin
            if (upd_en) begin
                mem_q[idx_q] <= mem_d;
                ref_q[idx_q] <= ref_d;
            end
            if (bus.cur_we && ({1'b0, bus.cur_addr} < N_V))
                cur_q[bus.cur_addr] <= bus.cur_data;
        end
    end

`ifdef THETA_ADAPT_EN
    // per-neuron adaptive thresholds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++)
                thr_q[n] <= THETA_BASE_V;
        end else if (upd_en) begin
            thr_q[idx_q] <= thr_d;
        end
    end
`endif

    // a push into a full FIFO still lands when the head leaves the same cycle
    always_comb begin
        full   = (cnt_q == (PW+1)'(FIFO_DEPTH));
        pop    = (cnt_q != '0) && bus.spike_ready;
        push   = upd_en && fire;
        accept = push && (!full || pop);
    end

    // spike FIFO payload, no reset needed since reads are qualified by count
    always_ff @(posedge clk) begin
        if (accept)
            fifo_q[wr_ptr_q] <= idx_q;
    end

    // spike FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (!accept && pop)
                cnt_q <= cnt_q - 1'b1;
            if (push && !accept)
                overflow_q <= 1'b1;
        end
    end

    assign bus.spike_valid = (cnt_q != '0);
    assign bus.spike_idx   = fifo_q[rd_ptr_q];
    assign bus.overflow    = overflow_q;

    // monitor read port; out-of-range index reads as zero
    always_comb begin
        bus.mon_membrane = '0;
`ifdef THETA_ADAPT_EN
        bus.mon_threshold = '0;
        if ({1'b0, bus.mon_idx} < N_V) begin
            bus.mon_membrane  = mem_q[bus.mon_idx];
            bus.mon_threshold = thr_q[bus.mon_idx];
        end
`else
        bus.mon_threshold = THETA_BASE_V;
        if ({1'b0, bus.mon_idx} < N_V)
            bus.mon_membrane = mem_q[bus.mon_idx];
`endif
    end
endmodule

// File: tb/tb_lif_array_core.sv
// Bench for lif_array_core: constant-table scenarios, hand sequences for
// reset/overflow/handshake/collision, and a random run against an
// event-level neuron model. Built with FIFO_DEPTH=2 so overflow is reachable.
module tb_lif_array_core;
    localparam int N     = 4;
    localparam int NW    = $clog2(N);
    localparam int VW    = 8;
    localparam int TAU   = 3;
    localparam int BASE  = 50;
    localparam int JUMP  = 30;
    localparam int REFR  = 3;
    localparam int DEPTH = 2;
`ifdef THETA_ADAPT_EN
    localparam bit ADAPT = 1'b1;
`else
    localparam bit ADAPT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_array_core_if #(.N_NEURONS(N), .V_WIDTH(VW)) bus();

    lif_array_core #(
        .N_NEURONS(N), .V_WIDTH(VW), .TAU_SHIFT(TAU), .THETA_BASE(BASE),
        .ADAPT_JUMP(JUMP), .REFRACT_STEPS(REFR), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    int mV[N], mI[N], mTh[N], mR[N];
    int mq[$];
    bit mOvf, mSweep, mDone;
    int mK;

    // values sampled in the most recent cycle
    int s_mem, s_th, s_idx;
    bit s_valid, s_ovf, s_busy, s_ready, s_done;
    logic [N-1:0] pop_mask;
    int done_cnt;

    typedef struct {
        bit rst;
        int nidx;
        int cur;
        int exp_v;
        int exp_th;
        bit exp_spike;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int thv(int adapt_val);
        return ADAPT ? adapt_val : BASE;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mV[n] = 0; mI[n] = 0; mTh[n] = BASE; mR[n] = 0;
        end
        mq.delete();
        mOvf = 0; mSweep = 0; mDone = 0; mK = 0;
    endtask

    // one neuron step by the LIF rules; returns 1 when it fires
    function automatic bit neuron_step(int k);
        bit f;
        int diff, d;
        f = (mR[k] == 0) && (mV[k] >= mTh[k]);
        if (f) begin
            mV[k] = 0;
            mR[k] = REFR;
            if (ADAPT) mTh[k] = (mTh[k] + JUMP > 255) ? 255 : mTh[k] + JUMP;
        end else begin
            if (mR[k] > 0) begin
                mV[k] = 0;
                mR[k] = mR[k] - 1;
            end else begin
                diff = mI[k] - mV[k];
                if (diff >= 0) d = diff / (1 << TAU);
                else d = -((-diff + (1 << TAU) - 1) / (1 << TAU));
                mV[k] = mV[k] + d;
                if (mV[k] < 0) mV[k] = 0;
                if (mV[k] > 255) mV[k] = 255;
            end
            if (mTh[k] > BASE) mTh[k] = mTh[k] - 1;
        end
        return f;
    endfunction

    // model effect of one rising edge
    task automatic model_edge(bit we, int addr, int data, bit sv, bit sr);
        bit pop, push;
        int pidx;
        pop  = (mq.size() > 0) && sr;
        push = 0;
        pidx = mK;
        if (mSweep) push = neuron_step(mK);
        if (we && addr < N) mI[addr] = data;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(pidx);
            else mOvf = 1;
        end
        mDone = mSweep && (mK == N - 1);
        if (mSweep) begin
            if (mK == N - 1) mSweep = 0;
            else mK++;
        end else if (sv) begin
            mSweep = 1;
            mK = 0;
        end
    endtask

    task automatic check_outputs(int midx);
        chk("step_ready", int'(bus.step_ready), int'(!mSweep));
        chk("busy", int'(bus.busy), int'(mSweep));
        chk("sweep_done", int'(bus.sweep_done), int'(mDone));
        chk("spike_valid", int'(bus.spike_valid), int'(mq.size() > 0));
        if (mq.size() > 0) chk("spike_idx", int'(bus.spike_idx), mq[0]);
        chk("overflow", int'(bus.overflow), int'(mOvf));
        chk("mon_membrane", int'(bus.mon_membrane), mV[midx]);
        chk("mon_threshold", int'(bus.mon_threshold), mTh[midx]);
    endtask

    // drive at negedge, sample and check #1 later, then advance the model
    task automatic cycle(bit we, int addr, int data, bit sv, bit sr, int midx);
        @(negedge clk);
        bus.cur_we      = we;
        bus.cur_addr    = NW'(addr);
        bus.cur_data    = VW'(data);
        bus.step_valid  = sv;
        bus.spike_ready = sr;
        bus.mon_idx     = NW'(midx);
        #1;
        check_outputs(midx);
        s_mem   = int'(bus.mon_membrane);
        s_th    = int'(bus.mon_threshold);
        s_valid = bus.spike_valid;
        s_idx   = int'(bus.spike_idx);
        s_ovf   = bus.overflow;
        s_busy  = bus.busy;
        s_ready = bus.step_ready;
        s_done  = bus.sweep_done;
        if (bus.spike_valid && sr) pop_mask[bus.spike_idx] = 1'b1;
        if (bus.sweep_done) done_cnt++;
        model_edge(we, addr, data, sv, sr);
    endtask

    // one full sweep including the sweep_done cycle
    task automatic do_step(bit sr, int midx);
        cycle(0, 0, 0, 1, sr, midx);
        repeat (N + 1) cycle(0, 0, 0, 0, sr, midx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.cur_we = 0; bus.step_valid = 0; bus.spike_ready = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < N; m++) begin
            bus.mon_idx = NW'(m);
            #1;
            chk("rst_membrane", int'(bus.mon_membrane), 0);
            chk("rst_threshold", int'(bus.mon_threshold), BASE);
        end
        chk("rst_step_ready", int'(bus.step_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_spike_valid", int'(bus.spike_valid), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_sweep_done", int'(bus.sweep_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r_we, r_sv, r_sr;
        int r_addr, r_data, r_mi;

        bus.cur_we = 0; bus.cur_addr = '0; bus.cur_data = '0;
        bus.step_valid = 0; bus.spike_ready = 0; bus.mon_idx = '0;
        pop_mask = '0; done_cnt = 0;
        model_reset();

        tbl.push_back('{1, 0, 200, 25,  BASE,    0});
        tbl.push_back('{0, 0, 200, 46,  BASE,    0});
        tbl.push_back('{0, 0, 200, 65,  BASE,    0});
        tbl.push_back('{0, 0, 200, 0,   thv(80), 1});
        tbl.push_back('{0, 0, 200, 0,   thv(79), 0});
        tbl.push_back('{0, 0, 200, 0,   thv(78), 0});
        tbl.push_back('{0, 0, 200, 0,   thv(77), 0});
        tbl.push_back('{0, 0, 200, 25,  thv(76), 0});
        tbl.push_back('{1, 1, 200, 25,  BASE,    0});
        tbl.push_back('{0, 1, 200, 46,  BASE,    0});
        tbl.push_back('{0, 1, 0,   40,  BASE,    0});
        tbl.push_back('{1, 1, 8,   1,   BASE,    0});
        tbl.push_back('{0, 1, 0,   0,   BASE,    0});
        tbl.push_back('{0, 1, 0,   0,   BASE,    0});

        repeat (2) @(negedge clk);
        do_reset();

        // table scenarios
        foreach (tbl[t]) begin
            if (tbl[t].rst) do_reset();
            cycle(1, tbl[t].nidx, tbl[t].cur, 0, 1, tbl[t].nidx);
            pop_mask = '0;
            do_step(1, tbl[t].nidx);
            chk($sformatf("tbl%0d_membrane", t), s_mem, tbl[t].exp_v);
            chk($sformatf("tbl%0d_threshold", t), s_th, tbl[t].exp_th);
            chk($sformatf("tbl%0d_spike", t), int'(pop_mask[tbl[t].nidx]), int'(tbl[t].exp_spike));
        end

        // reset mid-sweep
        do_reset();
        for (int m = 0; m < N; m++) cycle(1, m, 255, 0, 0, 0);
        do_step(0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("midsweep_busy", int'(s_busy), 1);
        do_reset();
        for (int m = 0; m < N; m++) do_step(1, m);

        // FIFO overflow with consumer stalled
        do_reset();
        for (int m = 0; m < N; m++) cycle(1, m, 255, 0, 0, 0);
        repeat (3) do_step(0, 0);
        chk("ovf_valid", int'(s_valid), 1);
        chk("ovf_head", s_idx, 0);
        chk("ovf_flag", int'(s_ovf), 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("drain_first", s_idx, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("drain_second_valid", int'(s_valid), 1);
        chk("drain_second", s_idx, 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("drain_empty", int'(s_valid), 0);
        chk("ovf_sticky", int'(s_ovf), 1);

        // step_valid held through a sweep gives exactly one extra sweep
        do_reset();
        done_cnt = 0;
        cycle(0, 0, 0, 1, 1, 0);
        for (int k = 0; k < N; k++) begin
            cycle(0, 0, 0, 1, 1, 0);
            chk("hs_busy", int'(s_busy), 1);
            chk("hs_not_ready", int'(s_ready), 0);
        end
        cycle(0, 0, 0, 1, 1, 0);
        chk("hs_done_pulse", int'(s_done), 1);
        chk("hs_ready_after", int'(s_ready), 1);
        repeat (2 * N + 2) cycle(0, 0, 0, 0, 1, 0);
        chk("hs_sweep_count", done_cnt, 2);
        chk("hs_idle_end", int'(s_busy), 0);

        // current write colliding with the update of the same neuron
        do_reset();
        cycle(0, 0, 0, 1, 1, 2);
        cycle(0, 0, 0, 0, 1, 2);
        cycle(0, 0, 0, 0, 1, 2);
        cycle(1, 2, 255, 0, 1, 2);
        cycle(0, 0, 0, 0, 1, 2);
        cycle(0, 0, 0, 0, 1, 2);
        chk("collide_old_current", s_mem, 0);
        do_step(1, 2);
        chk("collide_new_current", s_mem, 31);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset();
            r_we   = ($urandom_range(0, 99) < 30);
            r_addr = $urandom_range(0, N - 1);
            r_data = $urandom_range(0, 255);
            r_sv   = ($urandom_range(0, 99) < 60);
            r_sr   = ($urandom_range(0, 99) < 40);
            r_mi   = $urandom_range(0, N - 1);
            cycle(r_we, r_addr, r_data, r_sv, r_sr, r_mi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
